// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction and response bundle of the ALU sequencer.
// master = instruction source, slave = sequencer.
interface alu_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] instr;
    logic [7:0]  imm;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_carry;
    logic        busy;

    modport master (
        output in_valid, instr, imm,
        input  in_ready, out_valid, out_data, out_carry, busy
    );

    modport slave (
        input  in_valid, instr, imm,
        output in_ready, out_valid, out_data, out_carry, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: 8x8-bit register file driving the ALU opcode set.
// Ports: clk, rst_n (async low), bus (slave: in/out handshake, busy).
module alu_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.slave    bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_ASR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;
    localparam logic [3:0] OP_LDI = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1110;
    localparam logic [3:0] OP_RD  = 4'b1111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t      state_q, state_d;
    logic [7:0]  rf_q [8];
    logic [7:0]  rf_d [8];
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  rd_q, rd_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_carry_q, out_carry_d;

    logic        in_ready;
    logic        accept;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  x, y;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic [8:0]  wide;
    logic [15:0] acc_nxt;

    assign op = bus.instr[12:9];
    assign rd = bus.instr[8:6];
    assign rs = bus.instr[5:3];
    assign rt = bus.instr[2:0];
    assign x  = rf_q[rs];
    assign y  = rf_q[rt];
    assign accept = bus.in_valid & in_ready;

    // State register plus all datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && op == OP_MUL) state_d = S_MUL;
            S_MUL:  if (cnt_q == 3'd7) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = ~in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_carry = out_carry_q;

    // Combinational ALU; ADD/SUB use sign-extended 9-bit operands
    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: begin
                wide      = {x[7], x} + {y[7], y};
                alu_res   = wide[7:0];
                alu_carry = wide[8];
            end
            OP_SUB: begin
                wide      = {x[7], x} - {y[7], y};
                alu_res   = wide[7:0];
                alu_carry = wide[8];
            end
            OP_AND: alu_res = x & y;
            OP_OR:  alu_res = x | y;
            OP_NOT: alu_res = ~x;
            OP_XOR: alu_res = x ^ y;
            OP_NOR: alu_res = ~(x | y);
            OP_SHL: alu_res = y << x[2:0];
            OP_SHR: alu_res = y >> x[2:0];
            OP_ASR: alu_res = {x[7], x[7:1]};
            OP_ROL: alu_res = {x[6:0], x[7]};
            OP_ROR: alu_res = {x[0], x[7:1]};
            OP_EQ:  alu_res = (x == y) ? 8'd1 : 8'd0;
            OP_LDI: alu_res = bus.imm;
            OP_RD:  alu_res = x;
            default: alu_res = '0;
        endcase
    end

    // Writeback, response and shift-add multiplier datapath
    always_comb begin
        rf_d        = rf_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        acc_nxt     = acc_q + (mplier_q[0] ? mcand_q : 16'd0);
        if (state_q == S_IDLE) begin
            if (accept) begin
                if (op == OP_MUL) begin
                    mcand_d  = {8'b0, x};
                    mplier_d = y;
                    acc_d    = '0;
                    cnt_d    = '0;
                    rd_d     = rd;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = alu_res;
                    out_carry_d = alu_carry;
                    if (op != OP_RD) rf_d[rd] = alu_res;
                end
            end
        end else begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 3'd1;
            // Eighth iteration: product is complete this edge
            if (cnt_q == 3'd7) begin
                rf_d[rd_q]  = acc_nxt[7:0];
                out_valid_d = 1'b1;
                out_data_d  = acc_nxt[7:0];
                out_carry_d = |acc_nxt[15:8];
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed-vector bench for alu_sequencer.
// Drives the master side of the interface and checks responses.
module tb_alu_sequencer;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] AND = 4'b0010;
    localparam logic [3:0] OR  = 4'b0011;
    localparam logic [3:0] NOT = 4'b0100;
    localparam logic [3:0] XOR = 4'b0101;
    localparam logic [3:0] NOR = 4'b0110;
    localparam logic [3:0] SHL = 4'b0111;
    localparam logic [3:0] SHR = 4'b1000;
    localparam logic [3:0] ASR = 4'b1001;
    localparam logic [3:0] ROL = 4'b1010;
    localparam logic [3:0] ROR = 4'b1011;
    localparam logic [3:0] EQ  = 4'b1100;
    localparam logic [3:0] LDI = 4'b1101;
    localparam logic [3:0] MUL = 4'b1110;
    localparam logic [3:0] RD  = 4'b1111;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   low_cnt;
    int   seen;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an instruction, wait for the next edge, settle 1ns
    task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt,
                         input logic [7:0] im);
        bus.in_valid = 1'b1;
        bus.instr    = {op, rd, rs, rt};
        bus.imm      = im;
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input string tag, input logic [7:0] d,
                       input logic c);
        chk({tag, "_v"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_d"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_c"}, 32'(bus.out_carry), 32'(c));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        bus.imm      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;

        // Asynchronous reset with no clock edge
        issue(LDI, 3'd5, 3'd0, 3'd0, 8'h33);
        rsp("ldi5", 8'h33, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(bus.out_valid), 32'd0);
        chk("arst_od", 32'(bus.out_data), 32'd0);
        chk("arst_oc", 32'(bus.out_carry), 32'd0);
        chk("arst_rdy", 32'(bus.in_ready), 32'd1);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(RD, 3'd0, 3'd5, 3'd0, 8'h00);
        rsp("rd5", 8'h00, 1'b0);

        // Back-to-back ADD sequence
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'h7F);
        rsp("ldi1", 8'h7F, 1'b0);
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h01);
        rsp("ldi2", 8'h01, 1'b0);
        issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00);
        rsp("add3", 8'h80, 1'b0);
        issue(LDI, 3'd4, 3'd0, 3'd0, 8'h80);
        rsp("ldi4", 8'h80, 1'b0);
        issue(ADD, 3'd5, 3'd4, 3'd4, 8'h00);
        rsp("add5", 8'h00, 1'b1);
        idle();
        chk("b2b_end_ov", 32'(bus.out_valid), 32'd0);
        chk("b2b_hold_od", 32'(bus.out_data), 32'h00);

        // SUB and EQ
        issue(LDI, 3'd0, 3'd0, 3'd0, 8'h00);
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'h01);
        issue(SUB, 3'd2, 3'd0, 3'd1, 8'h00);
        rsp("sub", 8'hFF, 1'b1);
        issue(EQ, 3'd3, 3'd2, 3'd2, 8'h00);
        rsp("eq", 8'h01, 1'b0);
        issue(EQ, 3'd3, 3'd2, 3'd1, 8'h00);
        rsp("neq", 8'h00, 1'b0);

        // Shifts, rotates and logic on x=B4, 3
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'hB4);
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h03);
        issue(SHL, 3'd3, 3'd2, 3'd1, 8'h00);
        rsp("shl", 8'hA0, 1'b0);
        issue(SHR, 3'd3, 3'd2, 3'd1, 8'h00);
        rsp("shr", 8'h16, 1'b0);
        issue(ASR, 3'd3, 3'd1, 3'd0, 8'h00);
        rsp("asr", 8'hDA, 1'b0);
        issue(ROL, 3'd3, 3'd1, 3'd0, 8'h00);
        rsp("rol", 8'h69, 1'b0);
        issue(ROR, 3'd3, 3'd1, 3'd0, 8'h00);
        rsp("ror", 8'h5A, 1'b0);
        issue(NOT, 3'd3, 3'd1, 3'd0, 8'h00);
        rsp("not", 8'h4B, 1'b0);
        issue(AND, 3'd3, 3'd1, 3'd2, 8'h00);
        rsp("and", 8'h00, 1'b0);
        issue(OR, 3'd3, 3'd1, 3'd2, 8'h00);
        rsp("or", 8'hB7, 1'b0);
        issue(XOR, 3'd3, 3'd1, 3'd2, 8'h00);
        rsp("xor", 8'hB7, 1'b0);
        issue(NOR, 3'd3, 3'd1, 3'd2, 8'h00);
        rsp("nor", 8'h48, 1'b0);
        issue(RD, 3'd7, 3'd3, 3'd0, 8'h00);
        rsp("rd3", 8'h48, 1'b0);
        issue(RD, 3'd0, 3'd7, 3'd0, 8'h00);
        rsp("rd_nowb", 8'h00, 1'b0);

        // MUL 0F*11 with an ADD held on in_valid throughout
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'h0F);
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h11);
        issue(MUL, 3'd3, 3'd1, 3'd2, 8'h00);
        chk("mul_ov0", 32'(bus.out_valid), 32'd0);
        bus.instr = {ADD, 3'd4, 3'd3, 3'd3};
        low_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (!bus.in_ready) low_cnt++;
            @(posedge clk);
            #1;
        end
        chk("mul_lowcnt", 32'(low_cnt), 32'd8);
        chk("mul_rdy", 32'(bus.in_ready), 32'd1);
        rsp("mul1", 8'hFF, 1'b0);
        @(posedge clk);
        #1;
        rsp("add_after_mul", 8'hFE, 1'b1);

        issue(LDI, 3'd1, 3'd0, 3'd0, 8'h10);
        issue(MUL, 3'd5, 3'd1, 3'd2, 8'h00);
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rsp("mul2", 8'h10, 1'b1);
        issue(RD, 3'd0, 3'd5, 3'd0, 8'h00);
        rsp("mul2_wb", 8'h10, 1'b0);

        // Reset in the middle of a MUL
        issue(LDI, 3'd6, 3'd0, 3'd0, 8'h55);
        rsp("ldi6", 8'h55, 1'b0);
        issue(MUL, 3'd6, 3'd1, 3'd2, 8'h00);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
        chk("mrst_ov", 32'(bus.out_valid), 32'd0);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("mrst_noov", 32'(seen), 32'd0);
        issue(RD, 3'd0, 3'd6, 3'd0, 8'h00);
        rsp("mrst_r6", 8'h00, 1'b0);
        bus.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Register-file sequencer that drives the team's 8-bit ALU opcode set from a stream of 13-bit instructions. It holds eight 8-bit registers, accepts one instruction per cycle over a valid/ready handshake, writes results back, and reports each result on a one-cycle response strobe. It adds load-immediate and a multi-cycle shift-add multiply, using an internal FSM to stall the input. It sits between an instruction source (testbench or host FSM) and the combinational ALU datapath.

## Interface
- No parameters; all widths fixed (data 8, registers 8, instruction 13).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  sequencer can accept; transfer occurs when in_valid & in_ready are both high at a rising edge.
- instr  in  13  {op[12:9], rd[8:6], rs[5:3], rt[2:0]}.
- imm  in  8  immediate, used only by LDI.
- out_valid  out  1  one-cycle result strobe; no backpressure.
- out_data  out  8  result; holds its last value when out_valid is low.
- out_carry  out  1  carry/overflow flag qualified by out_valid.
- busy  out  1  high while a MUL is in progress (equals ~in_ready).

## Operation
- x = R[rs], y = R[rt], both read at the accept edge.
- op 0000 ADD: {carry,res} = {x[7],x} + {y[7],y}, taken mod 2^9.
- op 0001 SUB: {carry,res} = {x[7],x} - {y[7],y}, taken mod 2^9.
- 0010 AND, 0011 OR, 0100 NOT x, 0101 XOR, 0110 NOR.
- 0111: y << x[2:0]. 1000: y >> x[2:0] (logical shift).
- 1001: {x[7],x[7:1]}. 1010: {x[6:0],x[7]}. 1011: {x[0],x[7:1]}.
- 1100: res = (x==y) ? 1 : 0.
- 1101 LDI: res = imm.
- 1110 MUL: unsigned 8x8 multiply. res = product[7:0]; carry = |product[15:8].
- 1111 RD: res = R[rs]. No writeback.
- Carry is 0 for every op except ADD, SUB and MUL.
- Every op except RD writes res to R[rd]. rd=0 is an ordinary register.
- FSM states: IDLE and MUL.
  - IDLE: in_ready=1. Accepting a non-MUL op writes back and registers the response at the accept edge; the state stays IDLE.
  - Accepting a MUL latches mcand={8'b0,x}, mplier=y, acc=0, cnt=0, then moves to MUL.
  - MUL: in_ready=0. Each cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
  - On the edge where cnt reaches 7, the sequencer writes R[rd]=acc_final[7:0], registers the response, and returns to IDLE.
- in_valid while in MUL is ignored. The source must hold instr/imm until accepted.

## Timing
- Reset values: R0..R7=0, state=IDLE, in_ready=1, busy=0, out_valid=0, out_data=0, out_carry=0, acc/mcand/mplier/cnt=0.
- Non-MUL latency: accept at edge N; out_valid is high during cycle N+1 only, unless another op is accepted at edge N+1.
- Back-to-back accepts give one response per cycle.
- Writeback occurs at the accept edge. An instruction accepted at N+1 reads the value written at N, so there are no hazards.
- MUL latency: accept at edge N; iterations run at edges N+1..N+8. Writeback and out_valid rise after edge N+8.
  - in_ready is low from N+1 through N+8 and high again after edge N+8.
  - The next instruction can be accepted at edge N+9, and it sees the product.
- Reset asserted mid-MUL aborts the multiply with no writeback. All state returns to reset values immediately, without waiting for a clock edge.
- Reads in the same cycle as a write see the old value; there is no same-edge forwarding, and none is needed given the above.

## Test plan
- Reset: drive rst_n low mid-cycle -> all outputs read reset values with no clock edge. RD R5 after reset -> out_data=0x00.
- LDI R1=0x7F, LDI R2=0x01, ADD R3=R1+R2 -> 0x80, carry 0. LDI R4=0x80, ADD R5=R4+R4 -> 0x00, carry 1. All five issued back-to-back -> five consecutive out_valid cycles.
- LDI R0=0x00, R1=0x01, SUB R2=R0-R1 -> 0xFF, carry 1. EQ R3=(R2==R2) -> 0x01.
- LDI R1=0xB4 (x), R2=0x03 (y): shift-left 0111 with rs=R2, rt=R1 -> 0xA0. ASR 1001 on R1 -> 0xDA. ROL -> 0x69. ROR -> 0x5A. NOT -> 0x4B.
- MUL 0x0F*0x11 -> 0xFF, carry 0. MUL 0x10*0x11 -> 0x10, carry 1. Check in_ready low for exactly 8 cycles, and that an ADD held on in_valid meanwhile is accepted at N+9 using the new product.
- Start MUL with rd=R6 (old value 0x55), pulse rst_n low at cycle N+4 -> no out_valid, R6=0x00, in_ready=1.
